// File: rtl/vga_pkg.sv
// vga_pkg: shared mode constants, count width and decode helper
// for the VGA raster timing slice (800x600@60, 40 MHz pixel clock).
package vga_pkg;

  localparam int COUNT_W      = 11;
  localparam int COUNT_LIMIT  = 2048;

  localparam int VGA_H_ACTIVE = 800;
  localparam int VGA_H_FP     = 40;
  localparam int VGA_H_SYNC   = 128;
  localparam int VGA_H_BP     = 88;
  localparam int VGA_H_TOTAL  =
    VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 600;
  localparam int VGA_V_FP     = 1;
  localparam int VGA_V_SYNC   = 4;
  localparam int VGA_V_BP     = 23;
  localparam int VGA_V_TOTAL  =
    VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  function automatic logic sync_active(
    input logic [COUNT_W-1:0] count,
    input int                 start,
    input int                 width
  );
    int c;
    c = int'(count);
    return (c >= start) && (c < start + width);
  endfunction

endpackage

// File: rtl/vga_if.sv
// vga_if: raster timing bundle handed down the video pipeline.
// Modports: out (timing generator), in (draw stages).
interface vga_if;
  import vga_pkg::*;

  logic [COUNT_W-1:0] hcount;
  logic               hsync;
  logic               hblnk;
  logic [COUNT_W-1:0] vcount;
  logic               vsync;
  logic               vblnk;

  modport out (
    output hcount, hsync, hblnk,
    output vcount, vsync, vblnk
  );

  modport in (
    input hcount, hsync, hblnk,
    input vcount, vsync, vblnk
  );

endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrap counter with carry in/out and registered blank/sync
// decode. Ports: clk, rst_n, ci, count, blnk, sync, co (ci & last count).
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int   TOTAL      = VGA_H_TOTAL,
  parameter int   ACTIVE     = VGA_H_ACTIVE,
  parameter int   SYNC_START = VGA_H_ACTIVE + VGA_H_FP,
  parameter int   SYNC_W     = VGA_H_SYNC,
  parameter logic SYNC_POL   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ci,
  output logic [COUNT_W-1:0] count,
  output logic               blnk,
  output logic               sync,
  output logic               co
);

  logic               last;
  logic [COUNT_W-1:0] nxt;

  assign last = (int'(count) == TOTAL - 1);
  assign co   = ci & last;
  assign nxt  = last ? '0 : count + COUNT_W'(1);

  // Flags are decoded from the next count so they line up with
  // the count they are registered alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      blnk  <= 1'b0;
      sync  <= ~SYNC_POL;
    end else if (ci) begin
      count <= nxt;
      blnk  <= (int'(nxt) >= ACTIVE);
      sync  <= sync_active(nxt, SYNC_START, SYNC_W)
               ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// vga_timing: free-running VGA raster generator with frame pulse/counter.
// Ports: clk, rst_n, en, vga_out (vga_if.out), frame_start, frame_cnt.
module vga_timing
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = 1'b1,
  parameter int   FCNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  vga_if.out                vga_out,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > COUNT_LIMIT || V_TOTAL > COUNT_LIMIT) begin : g_bad_mode
    $error("vga_timing: line or frame total exceeds 2048");
  end

  logic hco;
  logic vco;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_W     (H_SYNC),
    .SYNC_POL   (SYNC_POL)
  ) u_h (
    .clk   (clk),
    .rst_n (rst_n),
    .ci    (en),
    .count (vga_out.hcount),
    .blnk  (vga_out.hblnk),
    .sync  (vga_out.hsync),
    .co    (hco)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_W     (V_SYNC),
    .SYNC_POL   (SYNC_POL)
  ) u_v (
    .clk   (clk),
    .rst_n (rst_n),
    .ci    (hco),
    .count (vga_out.vcount),
    .blnk  (vga_out.vblnk),
    .sync  (vga_out.vsync),
    .co    (vco)
  );

  // vco already folds in en, so a disabled cycle always clears
  // the pulse and it can never repeat across a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= vco;
      if (vco) begin
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: random-enable check of two vga_timing modes against
// a linear-position reference model.
module tb_vga_timing;
  import vga_pkg::*;

  localparam int BHT = 1056;
  localparam int BVT = 628;
  localparam int BFR = BHT * BVT;
  localparam int SHT = 10;
  localparam int SVT = 6;
  localparam int SFR = SHT * SVT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  always #5 clk = ~clk;

  vga_if vb ();
  vga_if vs ();

  logic       fs_b;
  logic       fs_s;
  logic [7:0] fc_b;
  logic [7:0] fc_s;

  vga_timing u_big (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .vga_out     (vb),
    .frame_start (fs_b),
    .frame_cnt   (fc_b)
  );

  vga_timing #(
    .H_ACTIVE (6), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .SYNC_POL (1'b0), .FCNT_W (8)
  ) u_sml (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .vga_out     (vs),
    .frame_start (fs_s),
    .frame_cnt   (fc_s)
  );

  int checks = 0;
  int errors = 0;

  int   pb, ps;
  int   frb, frs;
  logic efb, efs;

  function automatic logic [25:0] exp_pos(
    input int p,
    input int ha, input int hf, input int hs, input int hbp,
    input int va, input int vf, input int vsw, input int vbp,
    input logic pol
  );
    int ht, h, v;
    logic hsy, hbl, vsy, vbl;
    ht  = ha + hf + hs + hbp;
    h   = p % ht;
    v   = p / ht;
    hbl = (h >= ha);
    vbl = (v >= va);
    hsy = (h >= ha + hf && h < ha + hf + hs) ? pol : ~pol;
    vsy = (v >= va + vf && v < va + vf + vsw) ? pol : ~pol;
    return {11'(h), hsy, hbl, 11'(v), vsy, vbl};
  endfunction

  task automatic chk(input string tag,
                     input logic [34:0] obs,
                     input logic [34:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h want %h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/big"},
        {vb.hcount, vb.hsync, vb.hblnk,
         vb.vcount, vb.vsync, vb.vblnk, fs_b, fc_b},
        {exp_pos(pb, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1),
         efb, 8'(frb)});
    chk({tag, "/sml"},
        {vs.hcount, vs.hsync, vs.hblnk,
         vs.vcount, vs.vsync, vs.vblnk, fs_s, fc_s},
        {exp_pos(ps, 6, 1, 2, 1, 3, 1, 1, 1, 1'b0),
         efs, 8'(frs)});
  endtask

  task automatic model_reset();
    pb = 0; ps = 0; frb = 0; frs = 0;
    efb = 1'b0; efs = 1'b0;
  endtask

  task automatic model_adv(input logic e);
    if (e) begin
      pb  = (pb + 1) % BFR;
      ps  = (ps + 1) % SFR;
      efb = (pb == 0);
      efs = (ps == 0);
      if (efb) frb++;
      if (efs) frs++;
    end else begin
      efb = 1'b0;
      efs = 1'b0;
    end
  endtask

  task automatic step(input logic e, input string tag);
    en = e;
    @(posedge clk);
    model_adv(e);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 2 * BHT + 20; i++) step(1'b1, "run");

    for (int i = 0; i < 2 * BHT; i++) step(i[0], "toggle");

    for (int i = 0; i < 30000; i++)
      step($urandom_range(0, 3) != 0, "rand");

    for (int i = 0; i < 200 && ps != 2 * SHT + 5; i++)
      step(1'b1, "seek");

    en = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk);
    check_all("rst_hold");
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1) != 0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
